// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, branch redirect with response squash.
// Optional macro MISALIGN_TRAP_EN: misaligned redirect targets raise a sticky flag and halt fetch.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_branch_taken,
  input  logic [31:0] in_branch_address,
  input  logic        in_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_valid
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        out_misalign
`endif
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_e;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;
`endif

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_addr_q;
  logic        squash_q;
  logic        imem_req_q;
  logic        out_valid_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_instr_q;
  logic [31:0] target_d;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_q;
  logic        bad_target_d;
`endif

  always_comb begin
`ifdef MISALIGN_TRAP_EN
    target_d     = in_branch_address;
    bad_target_d = in_branch_taken && (in_branch_address[1:0] != 2'b00);
`else
    target_d     = in_branch_address & 32'hFFFF_FFFC;
`endif
  end

  // req_addr_q is the address of the request on the bus; fetch_pc_q may run ahead of it
  // while a squashed response is still outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_VECTOR;
      req_addr_q  <= RESET_VECTOR;
      squash_q    <= 1'b0;
      imem_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
          if (in_branch_taken) begin
            fetch_pc_q <= target_d;
            req_addr_q <= target_d;
          end else begin
            req_addr_q <= fetch_pc_q;
          end
        end
        FETCH: begin
          if (in_branch_taken) begin
            fetch_pc_q <= target_d;
            if (imem_ready) begin
              req_addr_q <= target_d;
              squash_q   <= 1'b0;
            end else begin
              squash_q   <= 1'b1;
            end
          end else if (imem_ready) begin
            if (squash_q) begin
              squash_q   <= 1'b0;
              req_addr_q <= fetch_pc_q;
            end else begin
              out_pc_q    <= req_addr_q;
              out_instr_q <= imem_rdata;
              out_valid_q <= 1'b1;
              fetch_pc_q  <= req_addr_q + 32'd4;
              imem_req_q  <= 1'b0;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (in_branch_taken) begin
            out_valid_q <= 1'b0;
            fetch_pc_q  <= target_d;
            req_addr_q  <= target_d;
            imem_req_q  <= 1'b1;
            state_q     <= FETCH;
          end else if (!in_stall) begin
            out_valid_q <= 1'b0;
            req_addr_q  <= fetch_pc_q;
            imem_req_q  <= 1'b1;
            state_q     <= FETCH;
          end
        end
`ifdef MISALIGN_TRAP_EN
        HALT: begin
        end
`endif
        default: state_q <= IDLE;
      endcase
`ifdef MISALIGN_TRAP_EN
      // Trap overrides whatever the state case decided this cycle.
      if (bad_target_d && (state_q != HALT)) begin
        misalign_q  <= 1'b1;
        state_q     <= HALT;
        imem_req_q  <= 1'b0;
        out_valid_q <= 1'b0;
        squash_q    <= 1'b0;
      end
`endif
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = req_addr_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;
  assign out_valid = out_valid_q;
`ifdef MISALIGN_TRAP_EN
  assign out_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table, directed corner sequences, random vs model.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        rst, br, st, rdy;
  logic [31:0] ba, rdata;
  logic        req, valid;
  logic [31:0] addr, pc, instr;
  logic        rv_rst, rv_req, rv_valid;
  logic [31:0] rv_addr, rv_pc, rv_instr;
`ifdef MISALIGN_TRAP_EN
  logic        mis, rv_mis;
`endif

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .in_branch_taken(br), .in_branch_address(ba), .in_stall(st),
    .imem_req(req), .imem_addr(addr), .imem_ready(rdy), .imem_rdata(rdata),
    .out_pc(pc), .out_instr(instr), .out_valid(valid)
`ifdef MISALIGN_TRAP_EN
    , .out_misalign(mis)
`endif
  );

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_rv (
    .clk(clk), .rst(rv_rst), .in_branch_taken(1'b0), .in_branch_address(32'h0), .in_stall(1'b0),
    .imem_req(rv_req), .imem_addr(rv_addr), .imem_ready(1'b1), .imem_rdata(32'h1234_5678),
    .out_pc(rv_pc), .out_instr(rv_instr), .out_valid(rv_valid)
`ifdef MISALIGN_TRAP_EN
    , .out_misalign(rv_mis)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "started" = left reset idle, "busy" = request outstanding,
  // "drop" = next response belongs to an abandoned path.
  bit          m_started, m_busy, m_valid, m_drop, m_halt, m_mis;
  logic [31:0] m_next, m_raddr, m_pc, m_instr;

  task automatic model_update();
    logic [31:0] tgt;
    tgt = TRAP ? ba : (ba & 32'hFFFF_FFFC);
    if (rst) begin
      m_started = 0; m_busy = 0; m_valid = 0; m_drop = 0; m_halt = 0; m_mis = 0;
      m_next = 32'h0; m_raddr = 32'h0; m_pc = 32'h0; m_instr = 32'h0;
    end else if (m_halt) begin
    end else if (TRAP && br && (ba[1:0] != 2'b00)) begin
      m_halt = 1; m_mis = 1; m_busy = 0; m_valid = 0; m_drop = 0;
    end else if (!m_started) begin
      m_started = 1; m_busy = 1;
      if (br) m_next = tgt;
      m_raddr = m_next;
    end else if (m_busy) begin
      if (br) begin
        m_next = tgt;
        if (rdy) begin m_raddr = tgt; m_drop = 0; end
        else m_drop = 1;
      end else if (rdy) begin
        if (m_drop) begin m_drop = 0; m_raddr = m_next; end
        else begin
          m_pc = m_raddr; m_instr = rdata; m_valid = 1; m_busy = 0; m_next = m_raddr + 32'd4;
        end
      end
    end else if (br) begin
      m_valid = 0; m_next = tgt; m_raddr = tgt; m_busy = 1;
    end else if (!st) begin
      m_valid = 0; m_raddr = m_next; m_busy = 1;
    end
  endtask

  task automatic check_model();
    chk("req", req, m_busy);
    if (m_busy) chk("addr", addr, m_raddr);
    chk("valid", valid, m_valid);
    chk("pc", pc, m_pc);
    chk("instr", instr, m_instr);
`ifdef MISALIGN_TRAP_EN
    chk("misalign", mis, m_mis);
`endif
  endtask

  task automatic step(input logic r, input logic b, input logic [31:0] a, input logic s,
                      input logic y, input logic [31:0] d);
    rst = r; br = b; ba = a; st = s; rdy = y; rdata = d;
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  typedef struct {
    logic r, b; logic [31:0] a; logic s, y; logic [31:0] d;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc, e_instr;
  } vec_t;
  vec_t tbl[21];

  initial begin
    rst = 1; br = 0; ba = 0; st = 0; rdy = 0; rdata = 0; rv_rst = 1;

    // Reset-vector instance: wrap from 0xFFFFFFFC to 0.
    step(1, 0, 0, 0, 0, 0);
    rv_rst = 0;
    step(1, 0, 0, 0, 0, 0);
    chk("rv_req1", rv_req, 1); chk("rv_addr1", rv_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    chk("rv_valid", rv_valid, 1); chk("rv_pc", rv_pc, 32'hFFFF_FFFC); chk("rv_instr", rv_instr, 32'h1234_5678);
    step(1, 0, 0, 0, 0, 0);
    chk("rv_req2", rv_req, 1); chk("rv_addr2", rv_addr, 32'h0); chk("rv_valid2", rv_valid, 0);

    //          r  b  a      s  y  d              req addr  vld pc     instr
    tbl[0]  = '{1, 0, 32'h0,   0, 1, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0};
    tbl[1]  = '{0, 0, 32'h0,   0, 1, 32'h0,        1, 32'h0,   0, 32'h0,   32'h0};
    tbl[2]  = '{0, 0, 32'h0,   0, 1, 32'h1000_0000, 0, 32'h0,  1, 32'h0,   32'h1000_0000};
    tbl[3]  = '{0, 0, 32'h0,   0, 1, 32'h0,        1, 32'h4,   0, 32'h0,   32'h1000_0000};
    tbl[4]  = '{0, 0, 32'h0,   0, 1, 32'h1000_0004, 0, 32'h0,  1, 32'h4,   32'h1000_0004};
    tbl[5]  = '{0, 0, 32'h0,   0, 1, 32'h0,        1, 32'h8,   0, 32'h4,   32'h1000_0004};
    tbl[6]  = '{0, 0, 32'h0,   0, 1, 32'h1000_0008, 0, 32'h0,  1, 32'h8,   32'h1000_0008};
    tbl[7]  = '{0, 0, 32'h0,   1, 1, 32'hBAD0_BAD0, 0, 32'h0,  1, 32'h8,   32'h1000_0008};
    tbl[8]  = '{0, 0, 32'h0,   1, 1, 32'hBAD0_BAD0, 0, 32'h0,  1, 32'h8,   32'h1000_0008};
    tbl[9]  = '{0, 0, 32'h0,   1, 1, 32'hBAD0_BAD0, 0, 32'h0,  1, 32'h8,   32'h1000_0008};
    tbl[10] = '{0, 0, 32'h0,   1, 1, 32'hBAD0_BAD0, 0, 32'h0,  1, 32'h8,   32'h1000_0008};
    tbl[11] = '{0, 0, 32'h0,   0, 1, 32'h0,        1, 32'hC,   0, 32'h8,   32'h1000_0008};
    tbl[12] = '{0, 0, 32'h0,   0, 1, 32'h1000_000C, 0, 32'h0,  1, 32'hC,   32'h1000_000C};
    tbl[13] = '{0, 0, 32'h0,   0, 1, 32'h0,        1, 32'h10,  0, 32'hC,   32'h1000_000C};
    tbl[14] = '{0, 1, 32'h100, 0, 0, 32'h0,        1, 32'h10,  0, 32'hC,   32'h1000_000C};
    tbl[15] = '{0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h10,  0, 32'hC,   32'h1000_000C};
    tbl[16] = '{0, 0, 32'h0,   0, 1, 32'hDEAD_BEEF, 1, 32'h100, 0, 32'hC,  32'h1000_000C};
    tbl[17] = '{0, 0, 32'h0,   0, 1, 32'h1000_0100, 0, 32'h0,  1, 32'h100, 32'h1000_0100};
    tbl[18] = '{0, 1, 32'h200, 1, 1, 32'h0,        1, 32'h200, 0, 32'h100, 32'h1000_0100};
    tbl[19] = '{0, 1, 32'h300, 0, 1, 32'h5555_5555, 1, 32'h300, 0, 32'h100, 32'h1000_0100};
    tbl[20] = '{0, 0, 32'h0,   0, 1, 32'h1000_0300, 0, 32'h0,  1, 32'h300, 32'h1000_0300};

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].b, tbl[i].a, tbl[i].s, tbl[i].y, tbl[i].d);
      chk($sformatf("tbl%0d_req", i), req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
    end

    // Second redirect while a squashed response is pending.
    step(0, 0, 0, 0, 0, 0);            chk("dbl_addr0", addr, 32'h304);
    step(0, 1, 32'h400, 0, 0, 0);
    step(0, 1, 32'h500, 0, 0, 0);      chk("dbl_hold_addr", addr, 32'h304);
    step(0, 0, 0, 0, 1, 32'hBADBAD00); chk("dbl_addr", addr, 32'h500); chk("dbl_drop", valid, 0);
    step(0, 0, 0, 0, 1, 32'hCAFE_0500);
    chk("dbl_valid", valid, 1); chk("dbl_pc", pc, 32'h500); chk("dbl_instr", instr, 32'hCAFE_0500);

    // Reset mid-request, late ready afterwards.
    step(0, 0, 0, 0, 0, 0);            chk("mid_addr", addr, 32'h504);
    step(1, 0, 0, 0, 0, 0);            chk("rst_req", req, 0); chk("rst_pc", pc, 32'h0);
    step(0, 0, 0, 0, 1, 32'hBADBAD11); chk("late_req", req, 1); chk("late_addr", addr, 32'h0);
    chk("late_valid", valid, 0);

    // Redirect while idle.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h40, 0, 0, 0);       chk("idle_addr", addr, 32'h40);
    step(0, 0, 0, 0, 1, 32'h4040_4040); chk("idle_pc", pc, 32'h40); chk("idle_valid", valid, 1);

    // Misaligned redirect target.
    step(0, 1, 32'h102, 1, 0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_flag", mis, 1); chk("mis_req", req, 0); chk("mis_valid", valid, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1'($urandom_range(0, 1)), 32'h200, 0, 1'($urandom_range(0, 1)), $urandom);
      chk("halt_req", req, 0); chk("halt_flag", mis, 1);
    end
    step(1, 0, 0, 0, 0, 0);            chk("mis_clear", mis, 0);
`else
    chk("mis_addr", addr, 32'h100); chk("mis_req", req, 1);
    step(0, 0, 0, 0, 1, 32'h7777_0100); chk("mis_pc", pc, 32'h100);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        r, b, s, y;
      logic [31:0] a;
      r = ($urandom_range(0, 99) == 0);
      b = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 2) == 0);
      y = ($urandom_range(0, 1) == 0);
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8;
      if ($urandom_range(0, 49) == 0) a[1:0] = 2'($urandom_range(1, 3));
      step(r, b, a, s, y, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
